branch_chkpt_ctrl: RTL
======================

# branch_chkpt_ctrl

Owns the branch checkpoint storage for the rename stage. Allocates a checkpoint tag to each renamed branch, captures the speculative RAT and free-list pointers, and keeps stored free-list state current as commit returns registers. On branch resolution it releases the checkpoint. On a mispredict it drives the global RAT and free-list recovery ports and squashes every younger checkpoint.

## Interface
Parameters:
- PREG_W, 6, physical register index width
- PREGS, 64, physical register count; must be a power of two equal to 2**PREG_W
- NUM_CHKPT, 8, checkpoint slots; 2..16

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- chkpt_avail_o  out  1  slot at the allocation pointer is free and no recovery is in progress; rename must not fire a branch while this is low
- chkpt_tag_o  out  4  tag the next branch receives (the allocation pointer, zero-extended)
- chkpt_we_i  in  1  branch renamed this cycle; capture a snapshot
- chkpt_rat_map_i  in  32*PREG_W  pre-update speculative RAT
- chkpt_fl_head_i, chkpt_fl_tail_i  in  PREG_W  free-list pointers
- chkpt_fl_free_count_i  in  $clog2(PREGS)+1  free-list count
- commit_free_valid_i  in  1  commit returned one register to the free list
- resolve_valid_i  in  1  branch resolved
- resolve_tag_i  in  4  tag of the resolved branch
- resolve_mispredict_i  in  1  resolved branch mispredicted
- rat_recover_o  out  1  restore pulse for the RAT
- rat_recover_map_o  out  32*PREG_W  RAT to restore
- fl_recover_o  out  1  restore pulse for the free list
- fl_recover_head_o, fl_recover_tail_o  out  PREG_W  free-list pointers to restore
- fl_recover_free_count_o  out  $clog2(PREGS)+1  free-list count to restore
- commit_hold_o  out  1  commit must not free a register this cycle
- mispredict_cnt_o  out  32  mispredict counter (see Configuration)

## Operation
State:
- valid[NUM_CHKPT] bitmask
- alloc_ptr, wrapping modulo NUM_CHKPT
- Per slot: RAT, head, tail, count
- Recovery register set
- State machine IDLE / RECOVER

Allocation:
- Slots are allocated in program order at alloc_ptr.
- On chkpt_we_i while in IDLE with valid[alloc_ptr]=0, write the snapshot into slot alloc_ptr, set its valid bit, and advance alloc_ptr.
- chkpt_we_i while chkpt_avail_o is low is a protocol error and is ignored.

Commit tracking:
- On each cycle with commit_free_valid_i, every valid slot increments its stored tail (wrapping modulo PREGS) and its stored count (saturating at PREGS).
- A slot written in the same cycle stores the incoming values without that increment; the free list applies that free itself.

Correct resolve:
- resolve_valid_i with resolve_mispredict_i=0 clears valid[tag].
- Releases may complete out of order; alloc_ptr does not move.
- Resolve for an invalid tag is ignored.

Mispredict (resolve_valid_i=1, resolve_mispredict_i=1, valid[tag]=1), in the same cycle:
- Load the recovery registers from slot tag, including this cycle's commit-free increment.
- Clear valid[tag] and every slot from tag+1 up to alloc_ptr-1 (circular).
- Set alloc_ptr to tag.
- Go to RECOVER.
- A mispredict for an invalid tag is ignored.

RECOVER (exactly one cycle):
- rat_recover_o, fl_recover_o and commit_hold_o are 1, with the recovery registers on the data outputs.
- chkpt_avail_o is 0, and chkpt_we_i and resolve_valid_i are ignored.
- The state then returns to IDLE.

Simultaneous events:
- A mispredict overrides chkpt_we_i in the same cycle; the younger branch is dropped.
- A correct resolve and an allocation of a different slot in the same cycle both take effect.

## Timing
Reset values:
- valid=0, alloc_ptr=0, state IDLE
- All recovery outputs 0, commit_hold_o=0, mispredict_cnt_o=0
- chkpt_avail_o=1, chkpt_tag_o=0

Latency:
- Snapshot is written at the clock edge of the chkpt_we_i cycle.
- A mispredict in cycle N produces recovery outputs in cycle N+1 only.
- A new branch may allocate from cycle N+2.

Other rules:
- chkpt_avail_o and chkpt_tag_o are combinational from registered state; no combinational path from any input to any output.
- Reset asserted mid-RECOVER drops to the reset state immediately; recovery outputs go to 0.

## Configuration
- CHKPT_STATS_EN defined: mispredict_cnt_o counts accepted mispredicts, wrapping at 2**32.
- CHKPT_STATS_EN undefined: the counter is not built and mispredict_cnt_o is tied to 0.

## Test plan
- Reset then 8 branch allocations with NUM_CHKPT=8 -> tags 0..7; chkpt_avail_o=0 after the 8th; resolve tag 3 correct -> avail stays 0 (alloc_ptr=0 still valid); resolve tag 0 -> avail=1 with tag 0.
- Allocate tag 2 with head=5, tail=20, count=15; three commit frees; mispredict tag 2 -> next cycle fl_recover_tail_o=23, count=18, head=5, rat_recover_map_o equal to the captured map, all recover pulses one cycle wide.
- Allocate tags 0..4; mispredict tag 1 -> valid={0}, chkpt_tag_o=1 two cycles later; resolve tag 3 afterwards is ignored.
- Stored tail=63 (PREG_W=6) plus one commit free -> recovered tail=0; count at 64 with another free -> stays 64.
- Same cycle: chkpt_we_i, commit free and mispredict of tag 0 -> no new slot, recovered count includes the free, commit_hold_o=1 in N+1.
- With CHKPT_STATS_EN: 3 mispredicts, 2 correct resolves and 1 invalid-tag mispredict -> mispredict_cnt_o=3; without the macro -> 0.

Source files
------------

// File: rtl/branch_chkpt_ctrl.sv
// Branch checkpoint controller for rename: allocates tags, snapshots RAT/free-list
// state and drives one-cycle recovery on mispredict. Optional stats: CHKPT_STATS_EN.
module branch_chkpt_ctrl #(
  parameter int PREG_W    = 6,
  parameter int PREGS     = 64,
  parameter int NUM_CHKPT = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       chkpt_avail_o,
  output logic [3:0]                 chkpt_tag_o,
  input  logic                       chkpt_we_i,
  input  logic [32*PREG_W-1:0]       chkpt_rat_map_i,
  input  logic [PREG_W-1:0]          chkpt_fl_head_i,
  input  logic [PREG_W-1:0]          chkpt_fl_tail_i,
  input  logic [$clog2(PREGS):0]     chkpt_fl_free_count_i,
  input  logic                       commit_free_valid_i,
  input  logic                       resolve_valid_i,
  input  logic [3:0]                 resolve_tag_i,
  input  logic                       resolve_mispredict_i,
  output logic                       rat_recover_o,
  output logic [32*PREG_W-1:0]       rat_recover_map_o,
  output logic                       fl_recover_o,
  output logic [PREG_W-1:0]          fl_recover_head_o,
  output logic [PREG_W-1:0]          fl_recover_tail_o,
  output logic [$clog2(PREGS):0]     fl_recover_free_count_o,
  output logic                       commit_hold_o,
  output logic [31:0]                mispredict_cnt_o
);

  localparam int PTR_W = $clog2(NUM_CHKPT);
  localparam int CNT_W = $clog2(PREGS) + 1;
  localparam int MAP_W = 32 * PREG_W;

  typedef enum logic {IDLE, RECOVER} state_e;

  state_e                 state_q, state_d;
  logic [NUM_CHKPT-1:0]   valid_q, valid_d, squash_mask;
  logic [PTR_W-1:0]       alloc_ptr_q, alloc_ptr_d, alloc_ptr_inc, tag_idx;
  logic                   tag_ok, tag_hit, mp_fire, cr_fire, alloc_fire;

  logic [MAP_W-1:0]       rat_q  [NUM_CHKPT];
  logic [PREG_W-1:0]      head_q [NUM_CHKPT];
  logic [PREG_W-1:0]      tail_q [NUM_CHKPT];
  logic [CNT_W-1:0]       cnt_q  [NUM_CHKPT];

  logic [MAP_W-1:0]       rec_map_q;
  logic [PREG_W-1:0]      rec_head_q, rec_tail_q, sel_tail;
  logic [CNT_W-1:0]       rec_cnt_q, sel_cnt;

  assign tag_idx       = resolve_tag_i[PTR_W-1:0];
  assign tag_ok        = ({1'b0, resolve_tag_i} < 5'(NUM_CHKPT));
  assign tag_hit       = tag_ok && valid_q[tag_idx];
  assign mp_fire       = (state_q == IDLE) && resolve_valid_i && resolve_mispredict_i && tag_hit;
  assign cr_fire       = (state_q == IDLE) && resolve_valid_i && !resolve_mispredict_i && tag_hit;
  assign alloc_fire    = (state_q == IDLE) && chkpt_we_i && !valid_q[alloc_ptr_q] && !mp_fire;
  assign alloc_ptr_inc = (alloc_ptr_q == PTR_W'(NUM_CHKPT - 1)) ? '0 : alloc_ptr_q + 1'b1;

  // Recovery data must already include a commit free landing in the mispredict cycle
  assign sel_tail = tail_q[tag_idx] + PREG_W'(commit_free_valid_i);
  assign sel_cnt  = (commit_free_valid_i && (cnt_q[tag_idx] != CNT_W'(PREGS)))
                    ? cnt_q[tag_idx] + 1'b1 : cnt_q[tag_idx];

  // Younger slots lie circularly between the mispredicted tag and alloc_ptr; when
  // alloc_ptr has wrapped onto the tag every other live slot is younger.
  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      if ((alloc_ptr_q == tag_idx) ||
          (((i + NUM_CHKPT - int'(tag_idx)) % NUM_CHKPT) <
           ((int'(alloc_ptr_q) + NUM_CHKPT - int'(tag_idx)) % NUM_CHKPT)))
        squash_mask[i] = 1'b1;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    alloc_ptr_d = alloc_ptr_q;
    if (mp_fire) begin
      valid_d     = valid_q & ~squash_mask;
      alloc_ptr_d = tag_idx;
    end else begin
      if (cr_fire)
        valid_d[tag_idx] = 1'b0;
      if (alloc_fire) begin
        valid_d[alloc_ptr_q] = 1'b1;
        alloc_ptr_d          = alloc_ptr_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      alloc_ptr_q <= '0;
      rec_map_q   <= '0;
      rec_head_q  <= '0;
      rec_tail_q  <= '0;
      rec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      alloc_ptr_q <= alloc_ptr_d;
      if (mp_fire) begin
        rec_map_q  <= rat_q[tag_idx];
        rec_head_q <= head_q[tag_idx];
        rec_tail_q <= sel_tail;
        rec_cnt_q  <= sel_cnt;
      end
    end
  end

  // A freshly written slot takes the incoming values; the free list already applied any same-cycle free
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CHKPT; i++) begin
      if (alloc_fire && (alloc_ptr_q == PTR_W'(i))) begin
        rat_q[i]  <= chkpt_rat_map_i;
        head_q[i] <= chkpt_fl_head_i;
        tail_q[i] <= chkpt_fl_tail_i;
        cnt_q[i]  <= chkpt_fl_free_count_i;
      end else if (commit_free_valid_i && valid_q[i]) begin
        tail_q[i] <= tail_q[i] + 1'b1;
        if (cnt_q[i] != CNT_W'(PREGS))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    if ((state_q == IDLE) && mp_fire)
      state_d = RECOVER;
  end

  always_comb begin
    chkpt_avail_o           = (state_q == IDLE) && !valid_q[alloc_ptr_q];
    chkpt_tag_o             = 4'(alloc_ptr_q);
    rat_recover_o           = (state_q == RECOVER);
    fl_recover_o            = (state_q == RECOVER);
    commit_hold_o           = (state_q == RECOVER);
    rat_recover_map_o       = (state_q == RECOVER) ? rec_map_q  : '0;
    fl_recover_head_o       = (state_q == RECOVER) ? rec_head_q : '0;
    fl_recover_tail_o       = (state_q == RECOVER) ? rec_tail_q : '0;
    fl_recover_free_count_o = (state_q == RECOVER) ? rec_cnt_q  : '0;
  end

`ifdef CHKPT_STATS_EN
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      mp_cnt_q <= '0;
    else if (mp_fire)
      mp_cnt_q <= mp_cnt_q + 32'd1;
  end

  assign mispredict_cnt_o = mp_cnt_q;
`else
  assign mispredict_cnt_o = '0;
`endif

endmodule
